fan_mode_scheduler: RTL and testbench

FAN_MODE_SCHEDULER -- requirements
Module: fan_mode_scheduler

---
 rtl/fan_mode_scheduler_pkg.sv | 40 ++++
 rtl/fan_mode_scheduler_if.sv | 27 ++
 rtl/fan_mode_scheduler_tick_gen.sv | 26 ++
 rtl/fan_mode_scheduler.sv | 125 ++++++++++++
 tb/tb_fan_mode_scheduler.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fan_mode_scheduler_pkg.sv
// rtl/fan_mode_scheduler_pkg.sv - shared fan mode encodings, enable constants and timer helpers
package fan_mode_scheduler_pkg;

  typedef enum logic [1:0] {
    MODE_DEFAULT = 2'd0,
    MODE_NATURAL = 2'd1,
    MODE_SLEEP   = 2'd2
  } fan_mode_e;

  localparam logic [2:0] EN_DEFAULT = 3'b001;
  localparam logic [2:0] EN_NATURAL = 3'b010;
  localparam logic [2:0] EN_SLEEP   = 3'b100;

  localparam int TMR_STEP_DEFAULT = 3600;
  localparam int REMAIN_W         = 14;

  typedef logic [REMAIN_W-1:0] remain_t;

  function automatic fan_mode_e next_mode(input fan_mode_e m);
    case (m)
      MODE_DEFAULT: return MODE_NATURAL;
      MODE_NATURAL: return MODE_SLEEP;
      default:      return MODE_DEFAULT;
    endcase
  endfunction

  function automatic logic [2:0] mode_enable(input fan_mode_e m);
    case (m)
      MODE_NATURAL: return EN_NATURAL;
      MODE_SLEEP:   return EN_SLEEP;
      default:      return EN_DEFAULT;
    endcase
  endfunction

  // Preset 3 at the default step is 10800 s, which fits the 14-bit countdown.
  function automatic remain_t preset_secs(input logic [1:0] sel, input int step);
    return REMAIN_W'(int'(sel) * step);
  endfunction

endpackage

// File: rtl/fan_mode_scheduler_if.sv
// rtl/fan_mode_scheduler_if.sv - button/duty inputs and status outputs of the fan scheduler
interface fan_mode_scheduler_if;
  import fan_mode_scheduler_pkg::*;

  logic          btn_mode;
  logic          btn_timer;
  logic [7:0]    duty_default;
  logic [7:0]    duty_natural;
  logic [7:0]    duty_sleep;
  logic [2:0]    enable;
  logic [1:0]    mode;
  logic [7:0]    duty_out;
  logic [1:0]    timer_sel;
  remain_t       remain_s;
  logic          expired;
  logic          halted;

  modport master (
    output btn_mode, btn_timer, duty_default, duty_natural, duty_sleep,
    input  enable, mode, duty_out, timer_sel, remain_s, expired, halted
  );

  modport slave (
    input  btn_mode, btn_timer, duty_default, duty_natural, duty_sleep,
    output enable, mode, duty_out, timer_sel, remain_s, expired, halted
  );
endinterface

// File: rtl/fan_mode_scheduler_tick_gen.sv
// rtl/fan_mode_scheduler_tick_gen.sv - free-running prescaler emitting a 1-cycle tick every DIV clocks
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  output logic tick_o
);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A clear restarts the count and swallows a tick landing on the same cycle.
  always_comb begin
    tick_o = (cnt_q == LAST) && !clear_i;
    cnt_d  = cnt_q + 1'b1;
    if (clear_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fan_mode_scheduler.sv
// rtl/fan_mode_scheduler.sv - fan mode selector, duty ramp and auto-off timer with halt
module fan_mode_scheduler
  import fan_mode_scheduler_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SEC_DIV  = CLK_HZ,
  parameter int RAMP_DIV = 100_000,
  parameter int TMR_STEP = TMR_STEP_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          btn_mode,
  input  logic          btn_timer,
  input  logic [7:0]    duty_default,
  input  logic [7:0]    duty_natural,
  input  logic [7:0]    duty_sleep,
  output logic [2:0]    enable,
  output logic [1:0]    mode,
  output logic [7:0]    duty_out,
  output logic [1:0]    timer_sel,
  output logic [13:0]   remain_s,
  output logic          expired,
  output logic          halted
);
  fan_mode_e  mode_q, mode_d;
  logic [2:0] enable_q, enable_d;
  logic [7:0] duty_q, duty_d, target;
  logic [1:0] tsel_q, tsel_d;
  remain_t    remain_q, remain_d;
  logic       expired_q, expired_d;
  logic       halted_q, halted_d;
  logic       sec_tick, ramp_tick;
  logic       mode_adv, timer_adv, clear_press;

  tick_gen #(.DIV(SEC_DIV)) u_sec_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (timer_adv),
    .tick_o  (sec_tick)
  );

  tick_gen #(.DIV(RAMP_DIV)) u_ramp_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (1'b0),
    .tick_o  (ramp_tick)
  );

  // A press while halted only releases the halt; it never advances anything.
  always_comb begin
    clear_press = halted_q && (btn_mode || btn_timer);
    mode_adv    = !halted_q && btn_mode;
    timer_adv   = !halted_q && btn_timer;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= MODE_DEFAULT;
      enable_q  <= EN_DEFAULT;
      duty_q    <= '0;
      tsel_q    <= '0;
      remain_q  <= '0;
      expired_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      enable_q  <= enable_d;
      duty_q    <= duty_d;
      tsel_q    <= tsel_d;
      remain_q  <= remain_d;
      expired_q <= expired_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_adv) mode_d = next_mode(mode_q);
    enable_d = mode_enable(mode_d);
  end

  // Reload beats the final decrement, so a press on that cycle suppresses expiry.
  always_comb begin
    tsel_d    = tsel_q;
    remain_d  = remain_q;
    expired_d = 1'b0;
    halted_d  = halted_q;
    if (clear_press) halted_d = 1'b0;
    if (timer_adv) begin
      tsel_d   = tsel_q + 2'd1;
      remain_d = preset_secs(tsel_d, TMR_STEP);
    end else if (sec_tick && (tsel_q != 2'd0) && (remain_q != '0)) begin
      remain_d = remain_q - 1'b1;
      if (remain_q == remain_t'(1)) begin
        expired_d = 1'b1;
        halted_d  = 1'b1;
        tsel_d    = 2'd0;
      end
    end
  end

  always_comb begin
    case (mode_q)
      MODE_NATURAL: target = duty_natural;
      MODE_SLEEP:   target = duty_sleep;
      default:      target = duty_default;
    endcase
    if (halted_q) target = 8'd0;
    duty_d = duty_q;
    if (ramp_tick) begin
      if (duty_q < target)      duty_d = duty_q + 8'd1;
      else if (duty_q > target) duty_d = duty_q - 8'd1;
    end
  end

  always_comb begin
    mode      = mode_q;
    enable    = enable_q;
    duty_out  = duty_q;
    timer_sel = tsel_q;
    remain_s  = remain_q;
    expired   = expired_q;
    halted    = halted_q;
  end
endmodule

// File: tb/tb_fan_mode_scheduler.sv
// tb/tb_fan_mode_scheduler.sv - bench for fan_mode_scheduler with cycle model and directed scenarios
module tb_fan_mode_scheduler;
  localparam int SEC_DIV  = 10;
  localparam int RAMP_DIV = 4;
  localparam int TMR_STEP = 3;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  fan_mode_scheduler_if fif();

  fan_mode_scheduler #(
    .SEC_DIV  (SEC_DIV),
    .RAMP_DIV (RAMP_DIV),
    .TMR_STEP (TMR_STEP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_mode     (fif.btn_mode),
    .btn_timer    (fif.btn_timer),
    .duty_default (fif.duty_default),
    .duty_natural (fif.duty_natural),
    .duty_sleep   (fif.duty_sleep),
    .enable       (fif.enable),
    .mode         (fif.mode),
    .duty_out     (fif.duty_out),
    .timer_sel    (fif.timer_sel),
    .remain_s     (fif.remain_s),
    .expired      (fif.expired),
    .halted       (fif.halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int duty;
    int tsel;
    int remain;
    int expired;
    int halted;
    int ramp_age;
    int sec_age;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.mode = 0; r.duty = 0; r.tsel = 0; r.remain = 0;
    r.expired = 0; r.halted = 0; r.ramp_age = 0; r.sec_age = 0;
    return r;
  endfunction

  // Ages count clock edges since reset / last reload; ticks fall on multiples of the divider.
  function automatic model_t model_step(input model_t s, input int bm, input int bt,
                                        input int dd, input int dn, input int ds);
    model_t n;
    int     target;
    n = s;
    target = (s.halted != 0) ? 0 : (s.mode == 0) ? dd : (s.mode == 1) ? dn : ds;
    n.ramp_age = s.ramp_age + 1;
    if (n.ramp_age % RAMP_DIV == 0) begin
      if (s.duty < target)      n.duty = s.duty + 1;
      else if (s.duty > target) n.duty = s.duty - 1;
    end
    n.expired = 0;
    if (s.halted != 0) begin
      if (bm != 0 || bt != 0) n.halted = 0;
    end else begin
      if (bm != 0) n.mode = (s.mode + 1) % 3;
      if (bt != 0) begin
        n.tsel   = (s.tsel + 1) % 4;
        n.remain = n.tsel * TMR_STEP;
      end
    end
    if (s.halted == 0 && bt != 0) begin
      n.sec_age = 0;
    end else begin
      n.sec_age = s.sec_age + 1;
      if (n.sec_age % SEC_DIV == 0 && s.tsel != 0 && s.remain > 0) begin
        n.remain = s.remain - 1;
        if (n.remain == 0) begin
          n.expired = 1;
          n.halted  = 1;
          n.tsel    = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else m <= model_step(m, int'(fif.btn_mode), int'(fif.btn_timer), int'(fif.duty_default),
                         int'(fif.duty_natural), int'(fif.duty_sleep));
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_mode",    int'(fif.mode),      m.mode);
    check("model_enable",  int'(fif.enable),    1 << m.mode);
    check("model_duty",    int'(fif.duty_out),  m.duty);
    check("model_tsel",    int'(fif.timer_sel), m.tsel);
    check("model_remain",  int'(fif.remain_s),  m.remain);
    check("model_expired", int'(fif.expired),   m.expired);
    check("model_halted",  int'(fif.halted),    m.halted);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic bm, input logic bt);
    fif.btn_mode  = bm;
    fif.btn_timer = bt;
    @(negedge clk);
    fif.btn_mode  = 1'b0;
    fif.btn_timer = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mode"},    int'(fif.mode),      0);
    check({tag, "_enable"},  int'(fif.enable),    1);
    check({tag, "_duty"},    int'(fif.duty_out),  0);
    check({tag, "_tsel"},    int'(fif.timer_sel), 0);
    check({tag, "_remain"},  int'(fif.remain_s),  0);
    check({tag, "_expired"}, int'(fif.expired),   0);
    check({tag, "_halted"},  int'(fif.halted),    0);
  endtask

  initial begin
    int n;
    reset_n          = 1'b1;
    fif.btn_mode     = 1'b0;
    fif.btn_timer    = 1'b0;
    fif.duty_default = 8'd80;
    fif.duty_natural = 8'd200;
    fif.duty_sleep   = 8'd100;
    #1 reset_n = 1'b0;
    cycles(3);
    check_reset_vals("reset");
    reset_n = 1'b1;

    // Ramp from 0 to the default duty: 80 steps of RAMP_DIV cycles.
    cycles(319);
    check("ramp_319", int'(fif.duty_out), 79);
    cycles(1);
    check("ramp_320", int'(fif.duty_out), 80);
    cycles(40);
    check("ramp_hold", int'(fif.duty_out), 80);

    press(1'b1, 1'b0);
    check("mode_1", int'(fif.mode), 1);
    check("enable_010", int'(fif.enable), 3'b010);
    cycles(500);
    check("duty_natural", int'(fif.duty_out), 200);
    press(1'b1, 1'b0);
    check("mode_2", int'(fif.mode), 2);
    check("enable_100", int'(fif.enable), 3'b100);
    cycles(500);
    check("duty_sleep", int'(fif.duty_out), 100);
    press(1'b1, 1'b0);
    check("mode_0", int'(fif.mode), 0);
    check("enable_001", int'(fif.enable), 3'b001);
    cycles(100);
    check("duty_default", int'(fif.duty_out), 80);
    press(1'b1, 1'b0);
    cycles(500);
    check("duty_natural_again", int'(fif.duty_out), 200);

    // Off-timer preset 1 expires after 3 seconds of 10 cycles.
    press(1'b0, 1'b1);
    check("tmr_sel_1", int'(fif.timer_sel), 1);
    check("tmr_remain_3", int'(fif.remain_s), 3);
    cycles(29);
    check("tmr_remain_1", int'(fif.remain_s), 1);
    check("tmr_no_exp_yet", int'(fif.expired), 0);
    cycles(1);
    check("tmr_expired", int'(fif.expired), 1);
    check("tmr_halted", int'(fif.halted), 1);
    check("tmr_sel_0", int'(fif.timer_sel), 0);
    check("tmr_mode_kept", int'(fif.mode), 1);
    cycles(1);
    check("tmr_exp_pulse", int'(fif.expired), 0);
    cycles(820);
    check("halt_duty_0", int'(fif.duty_out), 0);
    check("halt_still", int'(fif.halted), 1);

    press(1'b1, 1'b0);
    check("clear_halted", int'(fif.halted), 0);
    check("clear_mode_kept", int'(fif.mode), 1);
    check("clear_sel_kept", int'(fif.timer_sel), 0);
    cycles(820);
    check("resume_duty", int'(fif.duty_out), 200);

    // Reload on the final-decrement cycle wins and restarts the second prescaler.
    press(1'b0, 1'b1);
    cycles(29);
    press(1'b0, 1'b1);
    check("race_no_exp", int'(fif.expired), 0);
    check("race_not_halted", int'(fif.halted), 0);
    check("race_sel_2", int'(fif.timer_sel), 2);
    check("race_remain_6", int'(fif.remain_s), 6);
    cycles(9);
    check("restart_remain_6", int'(fif.remain_s), 6);
    cycles(1);
    check("restart_remain_5", int'(fif.remain_s), 5);
    press(1'b0, 1'b1);
    check("sel_3_remain_9", int'(fif.remain_s), 9);
    press(1'b0, 1'b1);
    check("sel_wrap_0", int'(fif.timer_sel), 0);
    check("sel_wrap_remain_0", int'(fif.remain_s), 0);
    cycles(40);

    press(1'b1, 1'b1);
    check("both_mode_2", int'(fif.mode), 2);
    check("both_sel_1", int'(fif.timer_sel), 1);
    cycles(30);
    check("both_halted", int'(fif.halted), 1);
    press(1'b1, 1'b1);
    check("both_clear_halted", int'(fif.halted), 0);
    check("both_clear_mode", int'(fif.mode), 2);
    check("both_clear_sel", int'(fif.timer_sel), 0);

    // Asynchronous reset in the middle of an upward ramp.
    press(1'b1, 1'b0);
    cycles(600);
    press(1'b1, 1'b0);
    n = 0;
    while (int'(fif.duty_out) != 150 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("mid_ramp_150", int'(fif.duty_out), 150);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async_reset");
    cycles(2);
    reset_n = 1'b1;
    cycles(3);
    check("post_reset_duty_0", int'(fif.duty_out), 0);
    cycles(1);
    check("post_reset_duty_1", int'(fif.duty_out), 1);
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
